// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and nibble placement helper for the
// Ethernet receive path.
package eth_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CAPTURE,
    FLUSH,
    DONE,
    DROP
  } rx_state_t;

  // Nibble n lands at 4*(n^1): the first nibble of each byte is its upper half.
  function automatic logic [4:0] nib_lsb(input logic [2:0] n);
    return {n ^ 3'd1, 2'b00};
  endfunction

endpackage

// File: rtl/mii_nibble_packer.sv
// Packs MII nibbles into 32-bit words; flush emits a partial word with
// its unfilled nibbles zero, clear discards the partial word.
module mii_nibble_packer
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  nibble,
  input  logic        nib_valid,
  input  logic        flush,
  input  logic        clear,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [2:0]  nib_cnt
);

  logic [31:0] acc;
  logic [31:0] acc_next;

  always_comb begin
    acc_next = acc;
    acc_next[nib_lsb(nib_cnt) +: 4] = nibble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      nib_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        acc     <= '0;
        nib_cnt <= '0;
      end else if (nib_valid) begin
        if (nib_cnt == 3'd7) begin
          word       <= acc_next;
          word_valid <= 1'b1;
          acc        <= '0;
          nib_cnt    <= '0;
        end else begin
          acc     <= acc_next;
          nib_cnt <= nib_cnt + 3'd1;
        end
      end else if (flush && nib_cnt != 3'd0) begin
        word       <= acc;
        word_valid <= 1'b1;
        acc        <= '0;
        nib_cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/mii_rx_capture.sv
// MII receive capture: assembles frames into the frame RAM, signals
// complete frames and counts dropped ones.
module mii_rx_capture
  import eth_pkg::*;
#(
  parameter int unsigned MIN_WORDS = 18,
  parameter int unsigned DEPTH     = eth_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rxd,
  input  logic              rx_dv,
  input  logic              rx_er,
  input  logic              rx_enable,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ena,
  output logic              newpacket,
  output logic [ADDR_W-1:0] frame_words,
  output logic [7:0]        drop_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  rx_state_t        state;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] words_total;
  logic             nib_valid;
  logic             flush;
  logic             clear;
  logic             word_valid;
  logic [31:0]      word;
  logic [2:0]       nib_cnt;
  logic             eof_ok;
  logic [7:0]       drop_inc;

  mii_nibble_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .nibble     (rxd),
    .nib_valid  (nib_valid),
    .flush      (flush),
    .clear      (clear),
    .word_valid (word_valid),
    .word       (word),
    .nib_cnt    (nib_cnt)
  );

  // Count includes a write in flight this cycle, so end/overflow checks see it.
  assign words_total = word_cnt + {{(CNT_W-1){1'b0}}, word_valid};
  assign eof_ok      = (words_total >= CNT_W'(MIN_WORDS));
  assign drop_inc    = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;

  assign wr_ena  = word_valid;
  assign wr_data = word;
  assign wr_addr = (word_cnt >= CNT_W'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                : word_cnt[ADDR_W-1:0];

  always_comb begin
    nib_valid = 1'b0;
    flush     = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: nib_valid = rx_dv && rx_enable;
      CAPTURE: begin
        if (rx_er)                               clear     = 1'b1;
        else if (!rx_dv)                         flush     = (nib_cnt != 3'd0);
        else if (words_total >= CNT_W'(DEPTH))   clear     = 1'b1;
        else                                     nib_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_IDLE;
      word_cnt    <= '0;
      newpacket   <= 1'b0;
      frame_words <= '0;
      drop_count  <= '0;
    end else begin
      newpacket <= 1'b0;
      if (word_valid) word_cnt <= word_cnt + CNT_W'(1);
      case (state)
        WAIT_IDLE: if (!rx_dv) state <= IDLE;
        IDLE: begin
          if (rx_dv) begin
            if (rx_enable) begin
              state    <= CAPTURE;
              word_cnt <= '0;
            end else begin
              state      <= DROP;
              drop_count <= drop_inc;
            end
          end
        end
        CAPTURE: begin
          if (rx_er) begin
            state      <= DROP;
            drop_count <= drop_inc;
          end else if (!rx_dv) begin
            if (nib_cnt != 3'd0) begin
              state <= FLUSH;
            end else if (eof_ok) begin
              state       <= DONE;
              newpacket   <= 1'b1;
              frame_words <= words_total[ADDR_W-1:0];
            end else begin
              state      <= IDLE;
              drop_count <= drop_inc;
            end
          end else if (words_total >= CNT_W'(DEPTH)) begin
            state      <= DROP;
            drop_count <= drop_inc;
          end
        end
        FLUSH: begin
          if (eof_ok) begin
            state       <= DONE;
            newpacket   <= 1'b1;
            frame_words <= words_total[ADDR_W-1:0];
          end else begin
            state      <= IDLE;
            drop_count <= drop_inc;
          end
        end
        DONE: state <= IDLE;
        DROP: if (!rx_dv) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_capture.sv
// Directed bench for mii_rx_capture: frames are driven nibble by nibble and
// RAM writes are logged by a negedge monitor.
module tb_mii_rx_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic        rx_enable;
  logic [31:0] wr_data;
  logic [8:0]  wr_addr;
  logic        wr_ena;
  logic        newpacket;
  logic [8:0]  frame_words;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  mii_rx_capture #(.MIN_WORDS(18), .DEPTH(512)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rx_dv       (rx_dv),
    .rx_er       (rx_er),
    .rx_enable   (rx_enable),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_ena      (wr_ena),
    .newpacket   (newpacket),
    .frame_words (frame_words),
    .drop_count  (drop_count)
  );

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  int unsigned cyc = 0;
  int unsigned wr_total = 0;
  int unsigned np_total = 0;
  int unsigned addr0_total = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned np_cyc = 0;
  logic [8:0]  last_addr = '0;
  logic [31:0] mem [0:511];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_ena === 1'b1) begin
      wr_total++;
      last_addr = wr_addr;
      mem[wr_addr] = wr_data;
      last_wr_cyc = cyc;
      if (wr_addr == 9'd0) addr0_total++;
    end
    if (newpacket === 1'b1) begin
      np_total++;
      np_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Preamble, SFD, then data bytes 0x00, 0x01, ...; upper nibble sent first.
  function automatic logic [7:0] fbyte(input int i);
    if (i < 7) return 8'h55;
    if (i == 7) return 8'hD5;
    return 8'(i - 8);
  endfunction

  function automatic logic [3:0] fnib(input int i);
    logic [7:0] b;
    b = fbyte(i / 2);
    return (i % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    return {fbyte(4*w+3), fbyte(4*w+2), fbyte(4*w+1), fbyte(4*w)};
  endfunction

  task automatic send_range(input int start, input int count, input int er_at);
    for (int i = start; i < start + count; i++) begin
      rxd   = fnib(i);
      rx_dv = 1'b1;
      rx_er = (i == er_at);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic end_frame();
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned w0, n0, a0;

  initial begin
    rst = 1'b1; rxd = 4'h0; rx_dv = 1'b0; rx_er = 1'b0; rx_enable = 1'b1;
    #1;
    check("rst_wr_ena", 32'(wr_ena), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_newpacket", 32'(newpacket), 32'd0);
    check("rst_frame_words", 32'(frame_words), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(3);

    // 72-byte frame
    w0 = wr_total; n0 = np_total;
    send_range(0, 144, -1); end_frame(); idle(6);
    check("f72_writes", wr_total - w0, 32'd18);
    check("f72_last_addr", 32'(last_addr), 32'd17);
    check("f72_word0", mem[0], 32'h55555555);
    check("f72_word1", mem[1], 32'hD5555555);
    for (int w = 2; w < 18; w++) check("f72_word", mem[w], exp_word(w));
    check("f72_word17", mem[17], 32'h3F3E3D3C);
    check("f72_frame_words", 32'(frame_words), 32'd18);
    check("f72_newpacket", np_total - n0, 32'd1);
    check("f72_drop", 32'(drop_count), 32'd0);

    // 147 nibbles: partial last word flushed
    w0 = wr_total; n0 = np_total;
    send_range(0, 147, -1); end_frame(); idle(6);
    check("f147_writes", wr_total - w0, 32'd19);
    check("f147_last_addr", 32'(last_addr), 32'd18);
    check("f147_flush_word", mem[18], 32'h00004040);
    check("f147_np_latency", np_cyc - last_wr_cyc, 32'd1);
    check("f147_frame_words", 32'(frame_words), 32'd19);
    check("f147_newpacket", np_total - n0, 32'd1);

    // rx_er on nibble 40
    w0 = wr_total; n0 = np_total;
    send_range(0, 144, 40); end_frame(); idle(6);
    check("err_newpacket", np_total - n0, 32'd0);
    check("err_drop", 32'(drop_count), 32'd1);
    check("err_no_late_writes", 32'(wr_total - w0 <= 5), 32'd1);

    // clean frame after the error
    w0 = wr_total; n0 = np_total;
    send_range(0, 144, -1); end_frame(); idle(6);
    check("post_err_writes", wr_total - w0, 32'd18);
    check("post_err_word1", mem[1], 32'hD5555555);
    check("post_err_frame_words", 32'(frame_words), 32'd18);
    check("post_err_newpacket", np_total - n0, 32'd1);
    check("post_err_drop", 32'(drop_count), 32'd1);

    // 20-byte runt
    w0 = wr_total; n0 = np_total;
    send_range(0, 40, -1); end_frame(); idle(6);
    check("runt_writes", wr_total - w0, 32'd5);
    check("runt_newpacket", np_total - n0, 32'd0);
    check("runt_drop", 32'(drop_count), 32'd2);

    // 520-word overflow
    w0 = wr_total; n0 = np_total; a0 = addr0_total;
    send_range(0, 520 * 8, -1); end_frame(); idle(6);
    check("ovf_writes", wr_total - w0, 32'd512);
    check("ovf_addr0_writes", addr0_total - a0, 32'd1);
    check("ovf_last_addr", 32'(last_addr), 32'd511);
    check("ovf_wr_addr_hold", 32'(wr_addr), 32'd511);
    check("ovf_newpacket", np_total - n0, 32'd0);
    check("ovf_drop", 32'(drop_count), 32'd3);

    // rx_enable low at frame start
    w0 = wr_total; n0 = np_total;
    rx_enable = 1'b0;
    send_range(0, 144, -1); end_frame();
    rx_enable = 1'b1;
    idle(6);
    check("dis_writes", wr_total - w0, 32'd0);
    check("dis_newpacket", np_total - n0, 32'd0);
    check("dis_drop", 32'(drop_count), 32'd4);

    // Back-to-back frames with the minimum two-cycle gap
    w0 = wr_total; n0 = np_total;
    send_range(0, 144, -1); end_frame(); idle(2);
    send_range(0, 147, -1); end_frame(); idle(6);
    check("b2b_writes", wr_total - w0, 32'd37);
    check("b2b_newpacket", np_total - n0, 32'd2);
    check("b2b_frame_words", 32'(frame_words), 32'd19);

    // Reset mid-frame, rx_dv held high through release
    send_range(0, 60, -1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_ena", 32'(wr_ena), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    check("mid_rst_frame_words", 32'(frame_words), 32'd0);
    send_range(60, 3, -1);
    rst = 1'b0;
    w0 = wr_total; n0 = np_total;
    send_range(63, 81, -1); end_frame(); idle(6);
    check("mid_rst_tail_writes", wr_total - w0, 32'd0);
    check("mid_rst_tail_newpacket", np_total - n0, 32'd0);
    check("mid_rst_tail_drop", 32'(drop_count), 32'd0);
    w0 = wr_total; n0 = np_total;
    send_range(0, 144, -1); end_frame(); idle(6);
    check("mid_rst_next_writes", wr_total - w0, 32'd18);
    check("mid_rst_next_newpacket", np_total - n0, 32'd1);
    check("mid_rst_next_frame_words", 32'(frame_words), 32'd18);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mii_rx_capture.md
MII_RX_CAPTURE -- requirements
Module: mii_rx_capture

Interface
REQ-001 The module SHALL have parameter MIN_WORDS, default 18, meaning the minimum number of words (preamble included) a frame needs to be accepted.
REQ-002 The module SHALL have parameter DEPTH, default 512, meaning the number of frame RAM words; the address width is 9.
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock (MII receive clock, one nibble per cycle).
REQ-004 The module SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have the port rxd, input, 4 bits: MII receive nibble.
REQ-006 The module SHALL have the port rx_dv, input, 1 bit: MII data valid.
REQ-007 The module SHALL have the port rx_er, input, 1 bit: MII receive error.
REQ-008 The module SHALL have the port rx_enable, input, 1 bit: high when the downstream parser is idle and the RAM may be overwritten.
REQ-009 The module SHALL have the ports wr_data (output, 32 bits), wr_addr (output, 9 bits) and wr_ena (output, 1 bit): the frame RAM write port.
REQ-010 The module SHALL have the port newpacket, output, 1 bit: a one-cycle pulse when a complete frame is in RAM.
REQ-011 The module SHALL have the port frame_words, output, 9 bits: the number of words written for the last accepted frame.
REQ-012 The module SHALL have the port drop_count, output, 8 bits: a saturating count of dropped frames.

Function
REQ-013 The FSM SHALL have the states WAIT_IDLE, IDLE, CAPTURE, FLUSH, DONE and DROP.
REQ-014 On reset exit the FSM SHALL be in WAIT_IDLE and SHALL move to IDLE on the first cycle with rx_dv=0, so no frame is captured from its middle.
REQ-015 In IDLE, rx_dv=1 with rx_enable=1 SHALL move to CAPTURE, with this nibble taken as nibble 0 of word 0.
REQ-016 In IDLE, rx_dv=1 with rx_enable=0 SHALL move to DROP.
REQ-017 Nibble packing: nibble n of a word (n = 0..7, in arrival order) SHALL be placed in bits [4*(n^1)+3 : 4*(n^1)].
REQ-018 As a result of REQ-017, byte k SHALL occupy bits [8k+7:8k], with its first-received nibble in the upper half.
REQ-019 The cycle after nibble 7 is sampled, the module SHALL drive wr_ena=1, wr_data equal to the assembled word, and wr_addr equal to the current word index.
REQ-020 The word index SHALL start at 0 and increment after each write.
REQ-021 wr_ena SHALL be 0 in every cycle that has no write.
REQ-022 In CAPTURE, rx_dv falling with a nibble count of 1..7 SHALL move to FLUSH, which writes the partial word with its unfilled nibbles set to zero in one cycle.
REQ-023 In CAPTURE, rx_dv falling with a nibble count of 0 SHALL move directly to the end-of-frame check.
REQ-024 End of frame: if the total words written are at least MIN_WORDS, the module SHALL move to DONE; otherwise it SHALL drop the frame, incrementing drop_count and returning to IDLE.
REQ-025 In DONE, the module SHALL set newpacket=1 for exactly one cycle, load frame_words with the total words written, and return to IDLE.
REQ-026 newpacket SHALL be asserted no earlier than the cycle after the final write.
REQ-027 rx_er=1 in CAPTURE SHALL move to DROP; writes stop immediately and no flush occurs.
REQ-028 Overflow: if rx_dv is still 1 after word DEPTH-1 has been written, the module SHALL stop writing and move to DROP.
REQ-029 After overflow, wr_addr SHALL NOT wrap to 0.
REQ-030 In DROP, the module SHALL increment drop_count once on entry, saturating at 255.
REQ-031 The module SHALL leave DROP for IDLE on the first cycle with rx_dv=0.
REQ-032 rx_enable falling during CAPTURE SHALL NOT abort the frame; it is sampled only in IDLE.
REQ-033 If rx_er=1 and rx_dv falls in the same cycle, the error SHALL take priority and the frame SHALL be dropped.
REQ-034 A new rx_dv rising edge in the cycle after DONE or DROP SHALL be accepted per REQ-015 and REQ-016.

Reset
REQ-035 Asserting rst SHALL immediately zero wr_ena, wr_addr, wr_data, newpacket, frame_words, drop_count and the nibble and word counters.
REQ-036 Asserting rst SHALL immediately set the state to WAIT_IDLE.
REQ-037 Reset mid-frame SHALL discard the frame; no newpacket SHALL be produced for it and drop_count SHALL NOT be incremented for it.

Structure
REQ-038 The ADDR_W=9 and DEPTH=512 constants and the state enum SHALL be placed in the shared package eth_pkg.
REQ-039 The nibble-to-word assembly (REQ-017, REQ-018, REQ-022 zero fill) SHALL be a sub-module, mii_nibble_packer, that outputs word_valid and word.
REQ-040 No other sub-module SHALL be used.

Verification
REQ-041 The bench SHALL cover this scenario: a 72-byte frame of 7x0x55, 0xD5, then bytes 0x00..0x3F -> 18 writes at addresses 0..17, word 0 = 0x55555555, word 1 = 0xD5555555, frame_words=18, one newpacket pulse.
REQ-042 The bench SHALL cover this scenario: a frame of 147 nibbles (18 words + 3 nibbles) -> the word-18 write has nibbles 3..7 zero, and newpacket follows the flush write by exactly 1 cycle.
REQ-043 The bench SHALL cover this scenario: rx_er pulsed on nibble 40 -> no newpacket and drop_count=1.
REQ-044 The bench SHALL cover this scenario: rx_er pulsed on nibble 40, followed by a clean frame -> the clean frame is captured normally.
REQ-045 The bench SHALL cover this scenario: a 20-byte runt frame -> no newpacket and drop_count increments.
REQ-046 The bench SHALL cover this scenario: a frame of 520 words -> 512 writes, no wrap to 0, no newpacket, drop_count increments.
REQ-047 The bench SHALL cover this scenario: rx_enable=0 at frame start -> zero writes and drop_count increments.
REQ-048 The bench SHALL cover this scenario: rst asserted mid-frame, then rx_dv held high through reset release -> no capture until rx_dv=0 is seen.
